upg_boot_ctrl: RTL and testbench



---
 rtl/upg_boot_ctrl.sv | 138 +++++++++++++
 tb/tb_upg_boot_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/upg_boot_ctrl.sv
// UART program-load sequencer: owns the programmer reset and CPU hold, forwards
// received words to instruction or data memory, counts them and aborts stalled loads.
module upg_boot_ctrl #(
    parameter int TIMEOUT_CYC = 20_000_000,
    parameter int RELEASE_CYC = 16
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        upg_wen_i,
    input  logic [14:0] upg_adr_i,
    input  logic [31:0] upg_dat_i,
    input  logic        upg_done_i,
    output logic        upg_rst_o,
    output logic        imem_wen_o,
    output logic        dmem_wen_o,
    output logic [13:0] mem_adr_o,
    output logic [31:0] mem_dat_o,
    output logic        cpu_hold_o,
    output logic [1:0]  state_o,
    output logic [15:0] word_cnt_o,
    output logic        err_o
);

    localparam int TO_W  = $clog2(TIMEOUT_CYC);
    localparam int REL_W = $clog2(RELEASE_CYC + 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYC - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic              wen_prev;
    logic [TO_W-1:0]   to_cnt;
    logic [REL_W-1:0]  rel_cnt;
    logic              acc;
    logic              enter_load;
    logic              enter_drain;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // An accepted write suppresses the timeout in the cycle it arrives.
    always_comb begin
        state_nxt   = state;
        acc         = 1'b0;
        enter_load  = 1'b0;
        enter_drain = 1'b0;
        case (state)
            RUN: begin
                if (start_i) begin
                    state_nxt  = LOAD;
                    enter_load = 1'b1;
                end
            end
            LOAD: begin
                acc = upg_wen_i && !wen_prev;
                if (upg_done_i) begin
                    state_nxt   = DRAIN;
                    enter_drain = 1'b1;
                end else if (!acc && to_cnt == TO_LAST) begin
                    state_nxt = ERR;
                end
            end
            DRAIN: begin
                if (rel_cnt == '0) begin
                    state_nxt = RUN;
                end
            end
            ERR: begin
                if (start_i) begin
                    state_nxt  = LOAD;
                    enter_load = 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wen_prev   <= 1'b0;
            to_cnt     <= '0;
            rel_cnt    <= '0;
            word_cnt_o <= '0;
            imem_wen_o <= 1'b0;
            dmem_wen_o <= 1'b0;
            mem_adr_o  <= '0;
            mem_dat_o  <= '0;
            upg_rst_o  <= 1'b1;
            cpu_hold_o <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            imem_wen_o <= acc && !upg_adr_i[14];
            dmem_wen_o <= acc && upg_adr_i[14];
            if (acc) begin
                mem_adr_o <= upg_adr_i[13:0];
                mem_dat_o <= upg_dat_i;
            end

            if (enter_load) begin
                wen_prev   <= 1'b0;
                to_cnt     <= '0;
                word_cnt_o <= '0;
            end else if (state == LOAD) begin
                wen_prev <= upg_wen_i;
                to_cnt   <= acc ? '0 : to_cnt + TO_W'(1);
                if (acc && word_cnt_o != 16'hFFFF) begin
                    word_cnt_o <= word_cnt_o + 16'd1;
                end
            end

            if (enter_drain) begin
                rel_cnt <= REL_LAST;
            end else if (state == DRAIN && rel_cnt != '0) begin
                rel_cnt <= rel_cnt - REL_W'(1);
            end

            // Status outputs are registered from the next state so they align with state_o.
            upg_rst_o  <= (state_nxt != LOAD);
            cpu_hold_o <= (state_nxt != RUN);
            err_o      <= (state_nxt == ERR);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_upg_boot_ctrl.sv
// Scoreboard bench for upg_boot_ctrl: directed load/drain/timeout/reset scenarios
// followed by randomized traffic against a behavioural model.
module tb_upg_boot_ctrl;

    localparam int T_CYC = 8;
    localparam int R_CYC = 4;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        upg_wen_i = 1'b0;
    logic [14:0] upg_adr_i = '0;
    logic [31:0] upg_dat_i = '0;
    logic        upg_done_i = 1'b0;
    logic        upg_rst_o, imem_wen_o, dmem_wen_o, cpu_hold_o, err_o;
    logic [13:0] mem_adr_o;
    logic [31:0] mem_dat_o;
    logic [1:0]  state_o;
    logic [15:0] word_cnt_o;

    upg_boot_ctrl #(.TIMEOUT_CYC(T_CYC), .RELEASE_CYC(R_CYC)) dut (
        .clock(clock), .rst_n(rst_n), .start_i(start_i), .upg_wen_i(upg_wen_i),
        .upg_adr_i(upg_adr_i), .upg_dat_i(upg_dat_i), .upg_done_i(upg_done_i),
        .upg_rst_o(upg_rst_o), .imem_wen_o(imem_wen_o), .dmem_wen_o(dmem_wen_o),
        .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o), .cpu_hold_o(cpu_hold_o),
        .state_o(state_o), .word_cnt_o(word_cnt_o), .err_o(err_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  st;
        logic        ur, ch, er, iw, dw;
        logic [15:0] cnt;
    } st_exp_t;

    typedef struct {
        logic        d;
        logic [13:0] a;
        logic [31:0] dat;
    } wr_exp_t;

    st_exp_t st_q[$];
    wr_exp_t wr_q[$];
    st_exp_t s;
    wr_exp_t w;
    int  total = 0;
    int  bad = 0;
    bit  mon_en = 1'b0;

    // Behavioural model: phase 0 idle, 1 loading, 2 releasing, 3 aborted.
    int  m_phase, m_idle, m_left, m_cnt;
    bit  m_prev;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_idle = 0; m_left = 0; m_cnt = 0; m_prev = 1'b0;
    endtask

    task automatic begin_load();
        m_phase = 1; m_cnt = 0; m_idle = 0; m_prev = 1'b0;
    endtask

    // Drive one cycle of inputs at the falling edge and predict the outcome of the next rising edge.
    task automatic cyc(input bit st, input bit wen, input logic [14:0] adr,
                       input logic [31:0] dat, input bit done);
        st_exp_t e;
        wr_exp_t x;
        bit a;
        @(negedge clock);
        start_i = st; upg_wen_i = wen; upg_adr_i = adr; upg_dat_i = dat; upg_done_i = done;
        a = 1'b0;
        case (m_phase)
            0: if (st) begin_load();
            1: begin
                a = wen && !m_prev;
                m_prev = wen;
                if (a) begin
                    x.d = adr[14]; x.a = adr[13:0]; x.dat = dat;
                    wr_q.push_back(x);
                    if (m_cnt < 65535) m_cnt++;
                    m_idle = 0;
                end else begin
                    m_idle++;
                end
                if (done) begin
                    m_phase = 2; m_left = R_CYC;
                end else if (m_idle >= T_CYC) begin
                    m_phase = 3;
                end
            end
            2: begin
                m_left--;
                if (m_left == 0) m_phase = 0;
            end
            default: if (st) begin_load();
        endcase
        e.st  = 2'(m_phase);
        e.ur  = (m_phase != 1);
        e.ch  = (m_phase != 0);
        e.er  = (m_phase == 3);
        e.iw  = a && !adr[14];
        e.dw  = a && adr[14];
        e.cnt = 16'(m_cnt);
        st_q.push_back(e);
    endtask

    task automatic idle(input int n, input bit st);
        for (int i = 0; i < n; i++) cyc(st, 1'b0, '0, '0, 1'b0);
    endtask

    always @(posedge clock) begin
        #2;
        if (mon_en) begin
            if (imem_wen_o || dmem_wen_o) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_strobe", {62'd0, imem_wen_o, dmem_wen_o}, 64'd0);
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_dmem_sel", dmem_wen_o, w.d);
                    chk("wr_adr", mem_adr_o, w.a);
                    chk("wr_dat", mem_dat_o, w.dat);
                end
            end
            if (st_q.size() > 0) begin
                s = st_q.pop_front();
                chk("state", state_o, s.st);
                chk("upg_rst", upg_rst_o, s.ur);
                chk("cpu_hold", cpu_hold_o, s.ch);
                chk("err", err_o, s.er);
                chk("imem_wen", imem_wen_o, s.iw);
                chk("dmem_wen", dmem_wen_o, s.dw);
                chk("word_cnt", word_cnt_o, s.cnt);
            end
        end
    end

    initial begin
        bit wen_r;
        model_reset();
        #12;
        chk("rst_state", state_o, 2'd0);
        chk("rst_upg_rst", upg_rst_o, 1'b1);
        chk("rst_hold", cpu_hold_o, 1'b0);
        chk("rst_cnt", word_cnt_o, 16'd0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_adr", mem_adr_o, 14'd0);
        chk("rst_dat", mem_dat_o, 32'd0);
        chk("rst_strobes", {imem_wen_o, dmem_wen_o}, 2'b00);
        @(negedge clock);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Start, single imem write with wen held, start ignored in LOAD.
        idle(2, 1'b0);
        cyc(1'b1, 1'b0, '0, '0, 1'b0);
        idle(1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 15'h0005, 32'hDEADBEEF, 1'b0);
        cyc(1'b1, 1'b0, '0, '0, 1'b0);
        // dmem write coinciding with done, then start ignored in DRAIN.
        cyc(1'b0, 1'b1, 15'h4003, 32'h12345678, 1'b1);
        cyc(1'b1, 1'b0, '0, '0, 1'b0);
        idle(5, 1'b0);

        // Timeout into ERR, then retry.
        cyc(1'b1, 1'b0, '0, '0, 1'b0);
        idle(T_CYC + 2, 1'b0);
        cyc(1'b1, 1'b0, '0, '0, 1'b0);
        idle(2, 1'b0);
        cyc(1'b0, 1'b1, 15'h0123, 32'hA5A5_0001, 1'b0);

        // Asynchronous reset while a strobe is showing.
        @(posedge clock);
        #3;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_state", state_o, 2'd0);
        chk("arst_upg_rst", upg_rst_o, 1'b1);
        chk("arst_hold", cpu_hold_o, 1'b0);
        chk("arst_strobes", {imem_wen_o, dmem_wen_o}, 2'b00);
        chk("arst_cnt", word_cnt_o, 16'd0);
        st_q.delete();
        wr_q.delete();
        model_reset();
        @(negedge clock);
        rst_n = 1'b1;
        start_i = 1'b0; upg_wen_i = 1'b0; upg_done_i = 1'b0;
        mon_en = 1'b1;

        // Randomized traffic.
        wen_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) wen_r = ~wen_r;
            cyc(($urandom_range(0, 15) == 0), wen_r, 15'($urandom), $urandom,
                ($urandom_range(0, 39) == 0));
        end
        idle(T_CYC + R_CYC + 2, 1'b0);
        @(posedge clock);
        #3;
        chk("wr_queue_drained", 64'(wr_q.size()), 64'd0);
        chk("st_queue_drained", 64'(st_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
